// File: rtl/trace_player_pkg.sv
// trace_player_pkg: shared state encoding, trace characters and character decode
package trace_player_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [7:0] CH_ONE  = "-";
    localparam logic [7:0] CH_ZERO = "_";
    localparam logic [7:0] CH_HOLD = ".";

    // Returns {bit, bad}; undefined characters decode to 0 and flag bad.
    function automatic logic [1:0] decode_char(input logic [7:0] ch, input logic prev);
        return ch == CH_ONE  ? 2'b10 :
               ch == CH_ZERO ? 2'b00 :
               ch == CH_HOLD ? {prev, 1'b0} : 2'b01;
    endfunction

endpackage

// File: rtl/trace_char_decode.sv
// trace_char_decode: combinational decode of one trace character for one channel
module trace_char_decode
    import trace_player_pkg::*;
(
    input  logic [7:0] ch_i,
    input  logic       prev_i,
    output logic       val_o,
    output logic       bad_o
);

    assign {val_o, bad_o} = decode_char(ch_i, prev_i);

endmodule

// File: rtl/trace_player.sv
// trace_player: replays per-channel ASCII traces one character per clock
module trace_player
    import trace_player_pkg::*;
#(
    parameter int                          CHANNELS = 4,
    parameter int                          LENGTH   = 32,
    parameter logic [CHANNELS*LENGTH*8-1:0] TRACES  = {CHANNELS*LENGTH{CH_ZERO}},
    parameter int                          WRAP_W   = 8,
    localparam int                         PW       = $clog2(LENGTH)
) (
    input  logic                clock_i,
    input  logic                resetn_i,
    input  logic                start_i,
    input  logic                stop_i,
    input  logic                pause_i,
    input  logic                loop_i,
    output logic [CHANNELS-1:0] out_o,
    output logic [PW-1:0]       pos_o,
    output logic                active_o,
    output logic                done_o,
    output logic [WRAP_W-1:0]   wraps_o,
    output logic                bad_char_o
);

    state_e              state_q, state_d;
    logic [PW-1:0]       pos_q, pos_d;
    logic [CHANNELS-1:0] out_q, out_d;
    logic [WRAP_W-1:0]   wraps_q, wraps_d;
    logic                bad_q, bad_d;

    logic                go, last;
    logic [PW-1:0]       nxt_pos;
    logic [CHANNELS-1:0] prev, dec_val, dec_bad;

    // A fresh start decodes position 0 with a held value of 0; otherwise '.' holds out.
    assign go      = start_i && state_q != RUN;
    assign last    = pos_q == PW'(LENGTH - 1);
    assign nxt_pos = (go || last) ? '0 : pos_q + 1'b1;
    assign prev    = go ? '0 : out_q;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [8*LENGTH-1:0] str;
        logic [7:0]          ch;
        assign str = TRACES[8*LENGTH*c +: 8*LENGTH];
        assign ch  = str[8*(LENGTH-1-int'(nxt_pos)) +: 8];
        trace_char_decode u_dec (
            .ch_i   (ch),
            .prev_i (prev[c]),
            .val_o  (dec_val[c]),
            .bad_o  (dec_bad[c])
        );
    end

    // Next state with precedence stop > pause > start.
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        out_d   = out_q;
        wraps_d = wraps_q;
        bad_d   = bad_q;
        if (stop_i) begin
            state_d = IDLE;
            pos_d   = '0;
            out_d   = '0;
        end else if (!pause_i) begin
            if (go) begin
                state_d = RUN;
                pos_d   = nxt_pos;
                out_d   = dec_val;
                wraps_d = '0;
                bad_d   = |dec_bad;
            end else if (state_q == RUN) begin
                if (last && !loop_i) begin
                    state_d = DONE;
                end else begin
                    pos_d   = nxt_pos;
                    out_d   = dec_val;
                    bad_d   = bad_q || |dec_bad;
                    wraps_d = last ? wraps_q + 1'b1 : wraps_q;
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= IDLE;
            pos_q   <= '0;
            out_q   <= '0;
            wraps_q <= '0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            out_q   <= out_d;
            wraps_q <= wraps_d;
            bad_q   <= bad_d;
        end
    end

    assign out_o      = out_q;
    assign pos_o      = pos_q;
    assign active_o   = state_q == RUN;
    assign done_o     = state_q == DONE;
    assign wraps_o    = wraps_q;
    assign bad_char_o = bad_q;

endmodule

// File: tb/tb_trace_player.sv
// tb_trace_player: directed and random playback checked against a string-level model
module tb_trace_player;

    localparam int CH  = 4;
    localparam int LEN = 8;
    localparam int WW  = 2;
    localparam logic [CH*LEN*8-1:0] TR = {"_-x_____", "-..._...", "__----__", "_-__-___"};

    logic          clock_i = 1'b0;
    logic          resetn_i = 1'b0;
    logic          start_i = 1'b0, stop_i = 1'b0, pause_i = 1'b0, loop_i = 1'b0;
    logic [CH-1:0] out_o;
    logic [2:0]    pos_o;
    logic          active_o, done_o, bad_char_o;
    logic [WW-1:0] wraps_o;

    trace_player #(.CHANNELS(CH), .LENGTH(LEN), .TRACES(TR), .WRAP_W(WW)) dut (
        .clock_i    (clock_i),
        .resetn_i   (resetn_i),
        .start_i    (start_i),
        .stop_i     (stop_i),
        .pause_i    (pause_i),
        .loop_i     (loop_i),
        .out_o      (out_o),
        .pos_o      (pos_o),
        .active_o   (active_o),
        .done_o     (done_o),
        .wraps_o    (wraps_o),
        .bad_char_o (bad_char_o)
    );

    always #5 clock_i = ~clock_i;

    int            errors = 0;
    int            checks = 0;
    string         tr[CH];
    int            m_state, m_pos, m_wraps;
    logic [CH-1:0] m_out;
    logic          m_bad;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic mreset();
        m_state = 0;
        m_pos   = 0;
        m_out   = '0;
        m_wraps = 0;
        m_bad   = 1'b0;
    endtask

    // Present character p of every trace string; fresh means '.' holds 0.
    task automatic present(input int p, input bit fresh);
        for (int c = 0; c < CH; c++) begin
            byte b = tr[c][p];
            logic pv = fresh ? 1'b0 : m_out[c];
            if (b == "-") m_out[c] = 1'b1;
            else if (b == "_") m_out[c] = 1'b0;
            else if (b == ".") m_out[c] = pv;
            else begin
                m_out[c] = 1'b0;
                m_bad = 1'b1;
            end
        end
        m_pos = p;
    endtask

    task automatic model(input bit s, input bit st, input bit p, input bit l);
        if (st) begin
            m_state = 0;
            m_pos   = 0;
            m_out   = '0;
        end else if (!p) begin
            if (s && m_state != 1) begin
                m_state = 1;
                m_wraps = 0;
                m_bad   = 1'b0;
                present(0, 1'b1);
            end else if (m_state == 1) begin
                if (m_pos < LEN - 1) present(m_pos + 1, 1'b0);
                else if (l) begin
                    m_wraps = (m_wraps + 1) % (1 << WW);
                    present(0, 1'b0);
                end else m_state = 2;
            end
        end
    endtask

    task automatic check_all();
        chk("out", 32'(out_o), 32'(m_out));
        chk("pos", 32'(pos_o), 32'(m_pos));
        chk("active", 32'(active_o), 32'(m_state == 1));
        chk("done", 32'(done_o), 32'(m_state == 2));
        chk("wraps", 32'(wraps_o), 32'(m_wraps));
        chk("bad_char", 32'(bad_char_o), 32'(m_bad));
    endtask

    task automatic step(input bit s, input bit st, input bit p, input bit l);
        start_i = s;
        stop_i  = st;
        pause_i = p;
        loop_i  = l;
        @(posedge clock_i);
        model(s, st, p, l);
        @(negedge clock_i);
        check_all();
    endtask

    logic [7:0] o0, o2, bs;

    initial begin
        tr[0] = "_-__-___";
        tr[1] = "__----__";
        tr[2] = "-..._...";
        tr[3] = "_-x_____";
        mreset();
        #7;
        chk("reset_out", 32'(out_o), 32'd0);
        chk("reset_active", 32'(active_o), 32'd0);
        check_all();
        @(negedge clock_i);
        resetn_i = 1'b1;

        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        o0[7] = out_o[0];
        o2[7] = out_o[2];
        bs[7] = bad_char_o;
        for (int i = 1; i < LEN; i++) begin
            step(0, 0, 0, 0);
            o0[7-i] = out_o[0];
            o2[7-i] = out_o[2];
            bs[7-i] = bad_char_o;
        end
        chk("seq_ch0", 32'(o0), 32'h48);
        chk("seq_hold_ch2", 32'(o2), 32'hF0);
        chk("seq_bad", 32'(bs), 32'h3F);
        chk("done_before_end", 32'(done_o), 32'd0);
        step(0, 0, 0, 0);
        chk("done_after_8", 32'(done_o), 32'd1);
        step(1, 0, 0, 0);
        chk("restart_from_done_pos", 32'(pos_o), 32'd0);
        step(0, 1, 0, 0);

        step(1, 0, 0, 1);
        for (int i = 1; i <= 40; i++) begin
            step(0, 0, 0, 1);
            if (i == 16) begin
                chk("loop_wraps2", 32'(wraps_o), 32'd2);
                chk("loop_pos0", 32'(pos_o), 32'd0);
            end
        end
        chk("loop_wraps_mod", 32'(wraps_o), 32'd1);
        step(0, 1, 0, 1);
        chk("stop_out", 32'(out_o), 32'd0);
        chk("stop_bad_holds", 32'(bad_char_o), 32'd1);

        step(1, 0, 0, 0);
        chk("start_clears_bad", 32'(bad_char_o), 32'd0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 0);
            chk("pause_pos", 32'(pos_o), 32'd3);
        end
        step(0, 0, 0, 0);
        chk("resume_pos", 32'(pos_o), 32'd4);
        step(0, 1, 1, 0);
        chk("stop_pause_active", 32'(active_o), 32'd0);

        step(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
        chk("pre_reset_pos", 32'(pos_o), 32'd5);
        #2 resetn_i = 1'b0;
        #1;
        mreset();
        chk("async_out", 32'(out_o), 32'd0);
        chk("async_pos", 32'(pos_o), 32'd0);
        chk("async_active", 32'(active_o), 32'd0);
        @(negedge clock_i);
        resetn_i = 1'b1;
        step(1, 0, 0, 0);
        chk("replay_pos", 32'(pos_o), 32'd0);

        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 99) < 10, $urandom_range(0, 99) < 3,
                 $urandom_range(0, 99) < 15, $urandom_range(0, 1) == 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/trace_player.md
# trace_player

Parametrised multi-channel waveform player for SVA regression benches: replays per-channel ASCII trace strings one character per clock onto a bit vector, driving the stimulus seen by the property under test. It generalises the fixed 4-channel/32-step sequencer with:
- arbitrary channel count and trace length
- start/stop/pause control
- loop mode
- a hold character
- position, status and error reporting

## Interface
- CHANNELS, 4, number of output channels (≥1)
- LENGTH, 32, characters per trace (≥2)
- TRACES, all '_', packed string of CHANNELS×LENGTH×8 bits; channel c = TRACES[8·LENGTH·c +: 8·LENGTH] (channel 0 is the rightmost string in a concatenation)
- WRAP_W, 8, width of the loop counter
- clock  in  1  sampling clock, rising edge
- resetn  in  1  asynchronous active-low reset
- start  in  1  begin playback from position 0 (IDLE/DONE only)
- stop  in  1  abort to IDLE
- pause  in  1  freeze playback while high
- loop  in  1  wrap at end instead of finishing; sampled at the last position
- out  out  CHANNELS  decoded channel values
- pos  out  $clog2(LENGTH)  position currently presented on out
- active  out  1  state is RUN
- done  out  1  state is DONE
- wraps  out  WRAP_W  completed loop wraps since last start, modulo 2^WRAP_W
- bad_char  out  1  sticky: an undefined character was decoded

## Operation
- Character at position p of a channel is bits [8·(LENGTH-1-p) +: 8] of its string, so the literal reads left-to-right in time.
- Decode rules, per channel:
  - '-' → 1
  - '_' → 0
  - '.' → current out bit (hold)
  - any other character → 0 and sets bad_char
- States: IDLE, RUN, DONE.
- IDLE:
  - out=0, pos=0.
  - start → RUN; same edge: pos←0, out←dec(0), wraps←0, bad_char←0 (then set if dec(0) is bad).
  - '.' at position 0 holds 0.
- RUN, pause=0:
  - pos<LENGTH-1 → pos←pos+1, out←dec(pos+1).
  - pos=LENGTH-1 and loop=1 → pos←0, out←dec(0), wraps←wraps+1 (wraps modulo 2^WRAP_W).
  - pos=LENGTH-1 and loop=0 → DONE; out and pos hold (last character persists).
- RUN, pause=1: all registers hold.
- start is ignored in RUN.
- DONE: outputs hold. start → RUN, as from IDLE.
- Control precedence: stop > pause > start.
  - stop in any state → IDLE next edge: out=0, pos=0; wraps and bad_char hold.
- bad_char clears only on start or reset.

## Timing
- Reset (async assert, sync release): state IDLE; out=0, pos=0, active=0, done=0, wraps=0, bad_char=0.
- All outputs are registered.
- Latency from a start edge: first character visible on out after that edge, i.e. 1 cycle.
- In RUN without pause, out advances exactly one character per clock.
- In loop mode, position LENGTH-1 is followed directly by position 0, with no gap cycle.
- Non-loop run: start at edge k, DONE at edge k+LENGTH.
- active/done change on the same edge as the state.
- Reset mid-playback forces reset values immediately, regardless of clock.

## Structure
- Package trace_player_pkg holds:
  - state enum (IDLE, RUN, DONE)
  - character constants CH_ONE="-", CH_ZERO="_", CH_HOLD="."
  - decode function returning {bit, bad}
- Sub-module trace_char_decode: combinational; inputs 8-bit character and previous bit; outputs value and bad. One instance per channel.
- Top contains the FSM, pos/wraps counters and out register.

## Test plan
- CHANNELS=2, LENGTH=8, ch0 "_-__-___", ch1 "__----__", start at cycle 2, loop=0 → out[0] 0,1,0,0,1,0,0,0 on consecutive cycles; done=1 after the 8th character; out holds 00 afterwards.
- Same traces, loop=1 for 20 cycles → pattern repeats with no gap; wraps=2 after 16 presented characters; pos 7→0 continuous.
- ch0 "-..._..." → out[0] 1,1,1,1,0,0,0,0; bad_char=0.
- ch0 "_-x_____" → out[0]=0 at position 2 and bad_char=1 from then on; next start clears bad_char.
- pause high for 3 cycles at pos=3 → pos and out frozen 3 cycles, then resume at 4; stop with pause=1 → IDLE, out=0.
- resetn pulsed low at pos=5 between clock edges → out=0, pos=0, active=0 immediately; start after release replays from position 0.
